// File: rtl/rx_fifo_buff.sv
// Receive-side circular buffer: registered head word, occupancy count and a sticky
// overrun flag raised when a push hits a full buffer with no simultaneous pop.
module rx_fifo_buff #(
   parameter int unsigned           DATA_WIDTH = 8,
   parameter int unsigned           DEPTH      = 4,
   parameter logic [DATA_WIDTH-1:0] IDLE_VAL   = '1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load_buffer,
   input  logic [DATA_WIDTH-1:0]      packet_data,
   input  logic                       data_read,
   input  logic                       flush,
   output logic [DATA_WIDTH-1:0]      rx_data,
   output logic                       data_ready,
   output logic                       overrun_error,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]         count_q, count_d;
   logic [CW-1:0]         remain;
   logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
   logic                  data_ready_q;
   logic                  overrun_q, overrun_d;
   logic                  full, empty, do_push, do_pop, ovr_evt;

   always_comb begin
      full     = (count_q == CW'(DEPTH));
      empty    = (count_q == '0);
      do_pop   = data_read && !empty;
      do_push  = load_buffer && (!full || data_read);
      ovr_evt  = load_buffer && full && !data_read;

      wr_ptr_d = wr_ptr_q + PW'(do_push);
      rd_ptr_d = rd_ptr_q + PW'(do_pop);
      count_d  = count_q + CW'(do_push) - CW'(do_pop);
      remain   = count_q - CW'(do_pop);

      // New head is the word being written only when nothing older survives this edge.
      rx_data_d = rx_data_q;
      if (do_push && (remain == '0)) begin
         rx_data_d = packet_data;
      end else if (count_d != '0) begin
         rx_data_d = mem[rd_ptr_d];
      end

      overrun_d = overrun_q;
      if (ovr_evt) begin
         overrun_d = 1'b1;
      end else if (data_read) begin
         overrun_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         rx_data_q    <= IDLE_VAL;
         data_ready_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         rx_data_q    <= rx_data_d;
         data_ready_q <= (count_d != '0);
         overrun_q    <= overrun_d;
      end
   end

   // Storage is not reset; only pointers and outputs are defined after rst/flush.
   always_ff @(posedge clk) begin
      if (!rst && !flush && do_push) begin
         mem[wr_ptr_q] <= packet_data;
      end
   end

   assign rx_data       = rx_data_q;
   assign data_ready    = data_ready_q;
   assign overrun_error = overrun_q;
   assign count         = count_q;

endmodule

// File: tb/tb_rx_fifo_buff.sv
// Bench for rx_fifo_buff: directed vector table, a mid-cycle reset pulse, and a random
// phase checked against a queue-based scoreboard.
module tb_rx_fifo_buff;

   logic       clk;
   logic       rst;
   logic       load_buffer;
   logic [7:0] packet_data;
   logic       data_read;
   logic       flush;
   logic [7:0] rx_data;
   logic       data_ready;
   logic       overrun_error;
   logic [2:0] count;

   int total;
   int bad;

   rx_fifo_buff #(
      .DATA_WIDTH (8),
      .DEPTH      (4),
      .IDLE_VAL   (8'hFF)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .load_buffer   (load_buffer),
      .packet_data   (packet_data),
      .data_read     (data_read),
      .flush         (flush),
      .rx_data       (rx_data),
      .data_ready    (data_ready),
      .overrun_error (overrun_error),
      .count         (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       fl;
      logic       ld;
      logic       rd;
      logic [7:0] din;
      logic [7:0] rx;
      logic       rdy;
      logic       ovr;
      logic [2:0] cnt;
   } vec_t;

   vec_t vecs[$];
   logic [7:0] sb[$];

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic r, input logic f, input logic l, input logic d,
                      input logic [7:0] din, input logic [7:0] rx, input logic rdy,
                      input logic ovr, input logic [2:0] cnt);
      vec_t v;
      v.rst = r; v.fl = f; v.ld = l; v.rd = d; v.din = din;
      v.rx = rx; v.rdy = rdy; v.ovr = ovr; v.cnt = cnt;
      vecs.push_back(v);
   endtask

   initial begin
      logic       ovr_m;
      logic       ld, rd;
      logic [7:0] d;
      int         sz;

      total = 0;
      bad   = 0;
      rst = 1'b1; flush = 1'b0; load_buffer = 1'b0; data_read = 1'b0; packet_data = 8'h00;

      //   rst fl ld rd din     rx     rdy ovr cnt
      add(1, 0, 0, 0, 8'h00, 8'hFF, 0, 0, 0);  // reset
      add(0, 0, 0, 0, 8'h00, 8'hFF, 0, 0, 0);  // idle
      add(0, 0, 1, 0, 8'hA1, 8'hA1, 1, 0, 1);
      add(0, 0, 1, 0, 8'hA2, 8'hA1, 1, 0, 2);
      add(0, 0, 1, 0, 8'hA3, 8'hA1, 1, 0, 3);
      add(0, 0, 0, 1, 8'h00, 8'hA2, 1, 0, 2);
      add(0, 0, 0, 1, 8'h00, 8'hA3, 1, 0, 1);
      add(0, 0, 0, 1, 8'h00, 8'hA3, 0, 0, 0);  // empty holds last popped
      add(0, 0, 0, 1, 8'h00, 8'hA3, 0, 0, 0);  // pop on empty ignored
      add(0, 0, 1, 0, 8'h10, 8'h10, 1, 0, 1);
      add(0, 0, 1, 0, 8'h11, 8'h10, 1, 0, 2);
      add(0, 0, 1, 0, 8'h12, 8'h10, 1, 0, 3);
      add(0, 0, 1, 0, 8'h13, 8'h10, 1, 0, 4);
      add(0, 0, 1, 0, 8'h55, 8'h10, 1, 1, 4);  // overrun
      add(0, 0, 0, 0, 8'h00, 8'h10, 1, 1, 4);  // sticky
      add(0, 0, 0, 1, 8'h00, 8'h11, 1, 0, 3);  // pop clears
      add(0, 0, 1, 0, 8'h14, 8'h11, 1, 0, 4);
      add(0, 0, 1, 1, 8'h77, 8'h12, 1, 0, 4);  // push+pop when full
      add(0, 0, 0, 1, 8'h00, 8'h13, 1, 0, 3);
      add(0, 0, 0, 1, 8'h00, 8'h14, 1, 0, 2);
      add(0, 0, 0, 1, 8'h00, 8'h77, 1, 0, 1);
      add(0, 0, 0, 1, 8'h00, 8'h77, 0, 0, 0);
      add(0, 0, 1, 1, 8'h01, 8'h01, 1, 0, 1);  // push+read on empty: push only
      add(0, 0, 1, 1, 8'h02, 8'h02, 1, 0, 1);
      add(0, 0, 1, 1, 8'h03, 8'h03, 1, 0, 1);
      add(0, 0, 1, 1, 8'h04, 8'h04, 1, 0, 1);
      add(0, 0, 1, 1, 8'h05, 8'h05, 1, 0, 1);
      add(0, 0, 1, 1, 8'h06, 8'h06, 1, 0, 1);
      add(0, 0, 0, 1, 8'h00, 8'h06, 0, 0, 0);
      add(0, 0, 1, 0, 8'hC1, 8'hC1, 1, 0, 1);
      add(0, 0, 1, 0, 8'hC2, 8'hC1, 1, 0, 2);
      add(0, 0, 1, 0, 8'hC3, 8'hC1, 1, 0, 3);
      add(0, 0, 1, 0, 8'hC4, 8'hC1, 1, 0, 4);
      add(0, 0, 1, 0, 8'hC5, 8'hC1, 1, 1, 4);
      add(0, 1, 1, 0, 8'h99, 8'hFF, 0, 0, 0);  // flush beats push
      add(0, 0, 1, 0, 8'hD1, 8'hD1, 1, 0, 1);
      add(1, 0, 1, 0, 8'hD2, 8'hFF, 0, 0, 0);  // reset during push
      add(1, 1, 1, 1, 8'hD3, 8'hFF, 0, 0, 0);
      add(0, 0, 1, 0, 8'hE1, 8'hE1, 1, 0, 1);

      foreach (vecs[i]) begin
         rst = vecs[i].rst; flush = vecs[i].fl; load_buffer = vecs[i].ld;
         data_read = vecs[i].rd; packet_data = vecs[i].din;
         @(posedge clk);
         #1;
         chk($sformatf("vec%0d rx_data", i), int'(rx_data), int'(vecs[i].rx));
         chk($sformatf("vec%0d data_ready", i), int'(data_ready), int'(vecs[i].rdy));
         chk($sformatf("vec%0d overrun", i), int'(overrun_error), int'(vecs[i].ovr));
         chk($sformatf("vec%0d count", i), int'(count), int'(vecs[i].cnt));
      end

      // rst pulse entirely between edges must be ignored
      rst = 1'b0; flush = 1'b0; load_buffer = 1'b0; data_read = 1'b0;
      #2 rst = 1'b1;
      #3 rst = 1'b0;
      @(posedge clk);
      #1;
      chk("glitch rst count", int'(count), 1);
      chk("glitch rst rx_data", int'(rx_data), 8'hE1);

      // Random phase against scoreboard queue
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      ovr_m = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if (sb.size() > 0) chk("sb head", int'(rx_data), int'(sb[0]));
         ld = ($urandom_range(0, 9) < 6);
         rd = ($urandom_range(0, 9) < 4);
         d  = 8'($urandom_range(0, 255));
         sz = sb.size();
         if (ld && sz == 4 && !rd) ovr_m = 1'b1;
         else if (rd) ovr_m = 1'b0;
         if (rd && sz > 0) void'(sb.pop_front());
         if (ld && (sz < 4 || rd)) sb.push_back(d);
         load_buffer = ld; data_read = rd; packet_data = d;
         @(posedge clk);
         #1;
         chk("sb count", int'(count), sb.size());
         chk("sb data_ready", int'(data_ready), int'(sb.size() != 0));
         chk("sb overrun", int'(overrun_error), int'(ovr_m));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
